// File: rtl/fifo_relay_ctrl.sv
// fifo_relay_ctrl: relays words from a source FIFO to a sink FIFO with enable, burst gaps and busy; FRC_WORD_CNT_EN adds Word_Cnt
module fifo_relay_ctrl #(
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
)(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              En,
  input  logic              Empty_Sig,
  input  logic [DATA_W-1:0] FIFO_Read_Data,
  output logic              Read_Req_Sig,
  input  logic              Full_Sig,
  output logic [DATA_W-1:0] FIFO_Write_Data,
  output logic              Write_Req_Sig,
  output logic              Busy
`ifdef FRC_WORD_CNT_EN
  ,
  output logic [CNT_W-1:0]  Word_Cnt
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WCHK, S_WR, S_GAP} state_t;
  localparam logic [2:0] LAT  = 3'(RD_LAT);
  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);
  state_t r_state, w_next;
  logic [2:0] r_lat;
  logic [7:0] r_burst;
  logic [DATA_W-1:0] r_data;
  logic r_rd, r_wr, r_busy;
  logic w_go, w_cap;
  if (RD_LAT < 1 || RD_LAT > 4 || MAX_BURST < 1 || MAX_BURST > 255 || CNT_W < 1) begin : g_bad_param
    $error("fifo_relay_ctrl: parameter out of range");
  end
  assign w_go  = En && !Empty_Sig;
  assign w_cap = (r_state == S_WAIT) && (r_lat == 3'd1);
  // next state: Empty_Sig and En only matter in IDLE and WR
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_go ? S_RD : S_IDLE;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  w_next = w_cap ? S_WCHK : S_WAIT;
      S_WCHK:  w_next = Full_Sig ? S_WCHK : S_WR;
      S_WR:    w_next = (r_burst == LAST) ? S_GAP : w_go ? S_RD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // state, latency countdown, burst count and captured word
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_burst <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      r_lat   <= (r_state == S_RD) ? LAT : (r_state == S_WAIT) ? r_lat - 3'd1 : r_lat;
      r_burst <= (r_state != S_WR) ? r_burst : (w_next == S_RD) ? r_burst + 8'd1 : 8'd0;
      r_data  <= w_cap ? FIFO_Read_Data : r_data;
    end
  end
  // strobes and busy are registered from the next state so outputs never see inputs combinationally
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rd   <= 1'b0;
      r_wr   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_rd   <= w_next == S_RD;
      r_wr   <= w_next == S_WR;
      r_busy <= w_next != S_IDLE;
    end
  end
  assign Read_Req_Sig    = r_rd;
  assign Write_Req_Sig   = r_wr;
  assign Busy            = r_busy;
  assign FIFO_Write_Data = r_data;
`ifdef FRC_WORD_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  // total pushes, wrapping naturally at 2^CNT_W
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_cnt <= '0;
    else r_cnt <= (r_state == S_WR) ? r_cnt + CNT_W'(1) : r_cnt;
  end
  assign Word_Cnt = r_cnt;
`endif
endmodule
